// File: rtl/writeback_stage_pkg.sv
// Core-wide constants shared by the writeback path: widths, writeback
// source selects and load opcode encodings (opcode[2:0]).
package writeback_stage_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_REG_DEF  = 5;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   typedef enum logic [2:0] {
      LOAD_LB  = 3'b000,
      LOAD_LH  = 3'b001,
      LOAD_LW  = 3'b011,
      LOAD_LBU = 3'b100,
      LOAD_LHU = 3'b101
   } load_type_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB bundle: pipeline controls and MEM results in, register file
// write port and status out. WB_RETIRE_CNT_EN adds the retire counter.
interface writeback_stage_if #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
);
   logic               i_stall;
   logic               i_flush;
   logic               i_valid;
   logic               i_regwrite;
   logic               i_halt;
   logic [1:0]         i_wb_sel;
   logic [2:0]         i_load_type;
   logic [1:0]         i_byte_off;
   logic [NB_DATA-1:0] i_alu_result;
   logic [NB_DATA-1:0] i_mem_data;
   logic [NB_DATA-1:0] i_pc_plus8;
   logic [NB_REG-1:0]  i_rd;
   logic               o_wenable;
   logic [NB_REG-1:0]  o_addr;
   logic [NB_DATA-1:0] o_data;
   logic               o_halted;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0]        o_retired;

   modport master (
      output i_stall, i_flush, i_valid, i_regwrite, i_halt, i_wb_sel,
             i_load_type, i_byte_off, i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      input  o_wenable, o_addr, o_data, o_halted, o_retired
   );
   modport slave (
      input  i_stall, i_flush, i_valid, i_regwrite, i_halt, i_wb_sel,
             i_load_type, i_byte_off, i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      output o_wenable, o_addr, o_data, o_halted, o_retired
   );
`else
   modport master (
      output i_stall, i_flush, i_valid, i_regwrite, i_halt, i_wb_sel,
             i_load_type, i_byte_off, i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      input  o_wenable, o_addr, o_data, o_halted
   );
   modport slave (
      input  i_stall, i_flush, i_valid, i_regwrite, i_halt, i_wb_sel,
             i_load_type, i_byte_off, i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      output o_wenable, o_addr, o_data, o_halted
   );
`endif
endinterface

// File: rtl/writeback_stage_load_align.sv
// Little-endian load alignment and extension. Halfword selection uses
// byte_off[1] only; unaligned halfwords are silently rounded down.
module writeback_stage_load_align
   import writeback_stage_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [2:0]         i_load_type,
   input  logic [1:0]         i_byte_off,
   input  logic [NB_DATA-1:0] i_mem_data,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/halfword, then extend according to the opcode.
   always_comb begin
      case (i_byte_off)
         2'd0:    byte_sel = i_mem_data[7:0];
         2'd1:    byte_sel = i_mem_data[15:8];
         2'd2:    byte_sel = i_mem_data[23:16];
         default: byte_sel = i_mem_data[31:24];
      endcase
      half_sel = i_byte_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
      case (i_load_type)
         LOAD_LB:  o_data = {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
         LOAD_LBU: o_data = {{(NB_DATA-8){1'b0}}, byte_sel};
         LOAD_LH:  o_data = {{(NB_DATA-16){half_sel[15]}}, half_sel};
         LOAD_LHU: o_data = {{(NB_DATA-16){1'b0}}, half_sel};
         default:  o_data = i_mem_data;   // LW and unknown encodings
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback mux driving the register file
// write port, and the sticky halt flag for the debug path.
// Optional: WB_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_REG  = NB_REG_DEF
) (
   input  logic           clk,
   input  logic           i_reset,
   writeback_stage_if.slave wb
);

   logic               valid_q,    valid_d;
   logic               regwrite_q, regwrite_d;
   logic               halt_q,     halt_d;
   logic [1:0]         wb_sel_q,   wb_sel_d;
   logic [2:0]         ltype_q,    ltype_d;
   logic [1:0]         boff_q,     boff_d;
   logic [NB_DATA-1:0] alu_q,      alu_d;
   logic [NB_DATA-1:0] mem_q,      mem_d;
   logic [NB_DATA-1:0] pc8_q,      pc8_d;
   logic [NB_REG-1:0]  rd_q,       rd_d;
   logic               halted_q,   halted_d;
   logic               load_en;
   logic [NB_DATA-1:0] load_data;

   // A fresh entry is taken only when nothing higher-priority intervenes.
   assign load_en = ~halted_q & ~wb.i_flush & ~wb.i_stall;

   // Next-state of the MEM/WB entry: halted > flush > stall > load.
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      halt_d     = halt_q;
      wb_sel_d   = wb_sel_q;
      ltype_d    = ltype_q;
      boff_d     = boff_q;
      alu_d      = alu_q;
      mem_d      = mem_q;
      pc8_d      = pc8_q;
      rd_d       = rd_q;
      if (halted_q || wb.i_flush) begin
         valid_d = 1'b0;
      end else if (!wb.i_stall) begin
         valid_d    = wb.i_valid;
         regwrite_d = wb.i_regwrite;
         halt_d     = wb.i_halt;
         wb_sel_d   = wb.i_wb_sel;
         ltype_d    = wb.i_load_type;
         boff_d     = wb.i_byte_off;
         alu_d      = wb.i_alu_result;
         mem_d      = wb.i_mem_data;
         pc8_d      = wb.i_pc_plus8;
         rd_d       = wb.i_rd;
      end
      // Sticky once a valid HALT has sat in the register for a cycle.
      halted_d = halted_q | (valid_q & halt_q);
   end

   // MEM/WB register and halt flag; reset clears everything immediately.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         halt_q     <= 1'b0;
         wb_sel_q   <= '0;
         ltype_q    <= '0;
         boff_q     <= '0;
         alu_q      <= '0;
         mem_q      <= '0;
         pc8_q      <= '0;
         rd_q       <= '0;
         halted_q   <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         halt_q     <= halt_d;
         wb_sel_q   <= wb_sel_d;
         ltype_q    <= ltype_d;
         boff_q     <= boff_d;
         alu_q      <= alu_d;
         mem_q      <= mem_d;
         pc8_q      <= pc8_d;
         rd_q       <= rd_d;
         halted_q   <= halted_d;
      end
   end

   writeback_stage_load_align #(.NB_DATA(NB_DATA)) u_load_align (
      .i_load_type (ltype_q),
      .i_byte_off  (boff_q),
      .i_mem_data  (mem_q),
      .o_data      (load_data)
   );

   // Writeback source select; the unused 11 encoding falls back to ALU.
   always_comb begin
      case (wb_sel_q)
         WB_SEL_MEM:  wb.o_data = load_data;
         WB_SEL_LINK: wb.o_data = pc8_q;
         default:     wb.o_data = alu_q;
      endcase
   end

   // r0 is hardwired zero and a halted core must not touch the GPRs.
   assign wb.o_wenable = valid_q & regwrite_q & ~halt_q & (rd_q != '0) & ~halted_q;
   assign wb.o_addr    = rd_q;
   assign wb.o_halted  = halted_q;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retired_q, retired_d;

   // Count at capture time so a stalled entry is counted only once.
   always_comb begin
      retired_d = retired_q;
      if (load_en && wb.i_valid && !wb.i_halt) retired_d = retired_q + 32'd1;
   end

   // Retire counter register, wraps naturally at 2^32.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) retired_q <= '0;
      else         retired_q <= retired_d;
   end

   assign wb.o_retired = retired_q;
`else
   logic unused_load_en;
   assign unused_load_en = load_en;
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and writeback logic of the 5-stage MIPS core. It sits directly upstream of the register file. It captures the memory-stage result each cycle and aligns and extends load data. It then drives the register file write port (enable, address, data) and tracks a sticky halt flag for the debug path.

## Interface
Parameters:
- NB_DATA, 32, datapath width (only 32 is supported)
- NB_REG, 5, register address width

Ports:
- clk  in  1  core clock; all state updates on posedge
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  hold the current MEM/WB contents
- i_flush  in  1  load a bubble instead of the MEM inputs
- i_valid  in  1  MEM stage carries a real instruction
- i_regwrite  in  1  instruction writes a GPR
- i_halt  in  1  instruction is HALT
- i_wb_sel  in  2  writeback source: 00 ALU, 01 memory, 10 link (PC+8), 11 treated as ALU
- i_load_type  in  3  opcode[2:0]: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; any other value is treated as LW
- i_byte_off  in  2  effective address [1:0]
- i_alu_result  in  NB_DATA  ALU result
- i_mem_data  in  NB_DATA  raw data-memory word
- i_pc_plus8  in  NB_DATA  link address
- i_rd  in  NB_REG  destination register
- o_wenable  out  1  register file write enable
- o_addr  out  NB_REG  register file write address
- o_data  out  NB_DATA  register file write data
- o_halted  out  1  sticky: HALT has retired
- o_retired  out  32  retired-instruction count (only with WB_RETIRE_CNT_EN)

## Operation
- MEM/WB register holds: valid, regwrite, halt, wb_sel, load_type, byte_off, alu_result, mem_data, pc_plus8, rd.
- Posedge update priority: reset > halted > flush > stall > load.
  - halted: valid is forced to 0; new inputs are ignored.
  - flush: valid is forced to 0.
  - stall: all fields keep their values.
  - load: capture all inputs.
- Load alignment (combinational from the registered fields), little-endian, byte k = mem_data[8k+7:8k]:
  - LB/LBU: byte byte_off, sign-extended or zero-extended.
  - LH/LHU: halfword byte_off[1]; byte_off[0] is ignored; no misalignment trap.
  - LW: full word.
- o_data: aligned load when wb_sel=01, pc_plus8 when wb_sel=10, otherwise alu_result.
- o_addr = rd.
- o_wenable = valid & regwrite & ~halt & (rd != 0) & ~o_halted. Writes to r0 are always suppressed.
- o_halted is set on the posedge while a valid HALT entry is held, and clears only on reset. HALT never writes a GPR.
- A stalled entry keeps o_wenable asserted with identical data, so repeated writes are idempotent.

## Timing
- Reset values: every registered field is 0, so o_wenable=0, o_addr=0, o_data=0, o_halted=0, o_retired=0.
- Latency: inputs are captured at posedge N; o_wenable/o_addr/o_data are valid after N; the register file commits at posedge N+1.
- The register file reads on negedge, so a write committed at posedge N+1 is visible to ID reads in that same cycle. This stage needs no bypass.
- o_halted rises one cycle after the HALT entry is captured.
- Flush and stall asserted together: flush wins and a bubble is loaded.
- Reset asserted mid-stall or while halted: state clears immediately (asynchronous). o_wenable drops without waiting for a clock.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - 32-bit o_retired increments at each posedge that loads a valid, non-HALT entry (not flush, not stall, not halted).
  - A stalled entry is counted once.
  - The counter wraps at 2^32.
- WB_RETIRE_CNT_EN undefined: no o_retired port and no counter logic.

## Structure
- Shared package (core-wide): WB_SEL_ALU/MEM/LINK constants, LOAD_LB/LH/LW/LBU/LHU opcode constants, NB_DATA/NB_REG defaults.
- One sub-module: load_align, combinational. Inputs: load_type, byte_off, mem_data. Output: extended word.

## Test plan
- Reset then ALU write: rd=5, wb_sel=00, alu_result=0x0000_1234, regwrite=1 -> next cycle o_wenable=1, o_addr=5, o_data=0x0000_1234.
- Loads with mem_data=0x8040_20F1, wb_sel=01:
  - LB off 0 -> 0xFFFF_FFF1
  - LBU off 3 -> 0x0000_0080
  - LH off 2 -> 0xFFFF_8040
  - LHU off 0 -> 0x0000_20F1
- Write to r0: rd=0, regwrite=1 -> o_wenable=0. JAL with rd=31, wb_sel=10, pc_plus8=0x0000_0048 -> o_data=0x0000_0048.
- Stall and flush:
  - Stall for 3 cycles while inputs change -> outputs unchanged.
  - Stall and flush in the same cycle -> o_wenable=0.
  - With WB_RETIRE_CNT_EN, the stalled entry increments o_retired by exactly 1.
- HALT then a valid write:
  - o_halted=1 one cycle after the HALT is captured.
  - The following instruction never asserts o_wenable.
  - Async reset clears o_halted without a clock edge.
